branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
- Sequences branch resolution in the ID stage of the 5-stage MIPS pipeline.
- Detects operand hazards for the ID-stage branch comparator, selects forwarded operands and stalls ID/IF with a countdown FSM until both operands are valid.
- Drives the condition evaluator and emits taken/valid and link-write requests.
- Keeps saturating branch performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- LINK_REG, 31, destination register for BLTZAL/BGEZAL link writes.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a live instruction
- id_op  in  6  opcode field
- id_rs  in  5  rs field
- id_rt  in  5  rt field (also REGIMM selector)
- rs_rdata  in  32  register-file rs read data
- rt_rdata  in  32  register-file rt read data
- ex_we, ex_is_load  in  1 each  EX-stage writeback enable / load flag
- ex_wreg  in  5  EX destination
- mem_we, mem_is_load  in  1 each  MEM writeback enable / load flag
- mem_wreg  in  5  MEM destination
- mem_result  in  32  MEM ALU result
- ext_stall  in  1  downstream freeze; holds all state
- stall_id  out  1  freeze PC and IF/ID
- branch_valid  out  1  branch resolved this cycle
- branch_taken  out  1  condition true (qualified by branch_valid)
- link_we  out  1  write PC+8 to LINK_REG
- link_reg  out  5  constant LINK_REG
- cnt_branch, cnt_taken, cnt_stall  out  CNT_W each  performance counters

Behaviour:
- Reset: state IDLE; wait counter 0; all counters 0; all 1-bit outputs 0.
- Branch decode:
  - BEQ 000100 and BNE 000101 need rs and rt.
  - BLEZ 000110 and BGTZ 000111 need rs only.
  - REGIMM 000001 with rt = 00000 BLTZ, 00001 BGEZ, 10000 BLTZAL, 10001 BGEZAL needs rs only.
  - Any other op or rt is not a branch: no stall, no outputs.
- Hazard per needed operand; register 0 is never a hazard:
  - Match ex_wreg with ex_we: wait 2 if ex_is_load, else 1.
  - Else match mem_wreg with mem_we and mem_is_load: wait 1.
  - Else match mem_wreg with mem_we, non-load: forward mem_result, no wait.
  - Else use register-file data; WB writes the regfile first half-cycle.
  - When both operands hazard, the larger wait wins.
- FSM, IDLE:
  - Branch in ID with wait = 0: resolve combinationally this cycle.
  - Wait > 0: load counter with wait, stall_id = 1, go to STALL.
- FSM, STALL:
  - stall_id = 1; counter decrements each non-ext_stall cycle.
  - When the counter reaches 0, return to IDLE; the next cycle re-evaluates hazards and normally resolves.
- Resolve cycle (combinational):
  - branch_valid = 1 and branch_taken = condition.
  - BGEZ/BGEZAL: rs[31] = 0.
  - BLTZ/BLTZAL: rs[31] = 1.
  - BGTZ: !rs[31] && rs != 0.
  - BLEZ: rs[31] || rs == 0.
  - BEQ/BNE: equality or inequality of rs and rt.
  - link_we = 1 for BLTZAL/BGEZAL regardless of taken.
- ext_stall = 1: FSM, counter and performance counters hold; branch_valid and link_we forced 0; stall_id passes through its current value.
- id_valid deasserted in STALL (flush/exception): abort to IDLE next edge, counter cleared, no resolution counted.
- Counters, saturating at all-ones, update on the clock edge:
  - cnt_branch +1 per resolve cycle.
  - cnt_taken +1 per taken resolve.
  - cnt_stall +1 per cycle stall_id = 1 and ext_stall = 0.
- Asynchronous reset asserted mid-STALL: immediate return to IDLE, counters cleared.

Decomposition:
- Shared defines package holds:
  - opcode constants for BEQ, BNE, BLEZ, BGTZ, REGIMM;
  - REGIMM rt codes for BLTZ, BGEZ, BLTZAL, BGEZAL;
  - FSM state encodings;
  - ZeroWord.
- One natural sub-module: branch_cond, a purely combinational condition evaluator on (op, rt, a, b) producing taken.

Test Plan:
- BEQ, rs = rt = 5, regs 0x10/0x10, no hazards -> same cycle branch_valid = 1, taken = 1, stall_id = 0; cnt_branch = 1, cnt_taken = 1.
- BNE rs = 8 with EX lw to r8 -> stall_id high 2 cycles, then resolve using regfile value; cnt_stall = 2.
- BGTZ rs = 9 with MEM ALU write r9 = 0x00000000 -> no stall, forwarded value used, taken = 0.
- BLTZAL rs = 0xFFFFFFFF -> taken = 1, link_we = 1, link_reg = 31. BGEZAL rs = 0x80000000 -> taken = 0, link_we = 1.
- Stall scenarios:
  - ext_stall asserted during a 2-cycle STALL for 3 cycles -> counter holds, total stall_id duration 5 cycles, cnt_stall = 2.
  - id_valid dropped mid-STALL -> IDLE, no resolution counted.
- Counter saturation:
  - Preload cnt_branch to all-ones via CNT_W = 4 build, resolve one branch -> stays 0xF.
  - Assert rst mid-STALL -> all outputs and counters 0 immediately.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared opcodes, REGIMM selectors, FSM states and constants for ID-stage branch resolution
package branch_resolve_ctrl_pkg;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  typedef enum logic {S_IDLE, S_STALL} state_t;
  function automatic logic is_regimm_br(input logic [4:0] rt);
    return rt == RT_BLTZ || rt == RT_BGEZ || rt == RT_BLTZAL || rt == RT_BGEZAL;
  endfunction
endpackage

// File: rtl/branch_resolve_ctrl_cond.sv
// branch_cond: combinational branch condition evaluator
// ports: op/rt select the branch kind, a/b are the resolved rs/rt operands, taken is the condition result
module branch_cond
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  always_comb begin
    taken = op == OP_BEQ  ? a == b :
            op == OP_BNE  ? a != b :
            op == OP_BLEZ ? a[31] || a == ZERO_WORD :
            op == OP_BGTZ ? !a[31] && a != ZERO_WORD :
            op == OP_REGIMM ? ((rt == RT_BLTZ || rt == RT_BLTZAL) ? a[31] :
                               (rt == RT_BGEZ || rt == RT_BGEZAL) ? !a[31] : 1'b0) :
            1'b0;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: ID-stage branch hazard detection, operand forwarding, stall FSM, resolution and perf counters
// ports: clk/rst (async active-high); id_* is the ID instruction and regfile reads; ex_*/mem_* describe
// in-flight writers; ext_stall freezes all state; outputs are stall_id, branch_valid/taken, link_we/link_reg
// and saturating counters cnt_branch/cnt_taken/cnt_stall
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      rs_rdata,
  input  logic [31:0]      rt_rdata,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wreg,
  input  logic             mem_we,
  input  logic             mem_is_load,
  input  logic [4:0]       mem_wreg,
  input  logic [31:0]      mem_result,
  input  logic             ext_stall,
  output logic             stall_id,
  output logic             branch_valid,
  output logic             branch_taken,
  output logic             link_we,
  output logic [4:0]       link_reg,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);
  state_t state;
  logic [1:0] cnt, rs_wait, rt_wait, hz_wait;
  logic rs_fwd, rt_fwd, is_branch, need_rt, is_link, cond, detect, resolve;
  logic [31:0] a, b;
  // returns {forward_from_mem, wait_cycles}; WB needs no handling since the regfile writes first half-cycle
  function automatic logic [2:0] hazard(input logic [4:0] r, input logic need);
    if (!need || r == 5'd0) return 3'b000;
    if (ex_we && ex_wreg == r) return {1'b0, ex_is_load ? 2'd2 : 2'd1};
    if (mem_we && mem_wreg == r) return mem_is_load ? 3'b001 : 3'b100;
    return 3'b000;
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && c != '1) ? c + CNT_W'(1) : c;
  endfunction
  always_comb begin
    is_branch = id_valid && (id_op == OP_BEQ || id_op == OP_BNE || id_op == OP_BLEZ || id_op == OP_BGTZ ||
                             (id_op == OP_REGIMM && is_regimm_br(id_rt)));
    need_rt = id_op == OP_BEQ || id_op == OP_BNE;
    is_link = id_op == OP_REGIMM && (id_rt == RT_BLTZAL || id_rt == RT_BGEZAL);
    {rs_fwd, rs_wait} = hazard(id_rs, 1'b1);
    {rt_fwd, rt_wait} = hazard(id_rt, need_rt);
    hz_wait = rs_wait > rt_wait ? rs_wait : rt_wait;
    a = rs_fwd ? mem_result : rs_rdata;
    b = rt_fwd ? mem_result : rt_rdata;
    detect = state == S_IDLE && is_branch && hz_wait != 2'd0;
    resolve = state == S_IDLE && is_branch && hz_wait == 2'd0;
    // outputs read as 0 the instant async reset is applied, not just after the state clears
    stall_id = !rst && (state == S_STALL || detect);
    branch_valid = !rst && !ext_stall && resolve;
    branch_taken = branch_valid && cond;
    link_we = branch_valid && is_link;
    link_reg = 5'(LINK_REG);
  end
  branch_cond u_cond (
    .op   (id_op),
    .rt   (id_rt),
    .a    (a),
    .b    (b),
    .taken(cond)
  );
  // the detecting IDLE cycle is itself the first stall cycle, so STALL only covers the remaining wait-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 2'd0;
      cnt_branch <= '0;
      cnt_taken  <= '0;
      cnt_stall  <= '0;
    end else if (!ext_stall) begin
      if (detect) begin
        cnt   <= hz_wait - 2'd1;
        state <= hz_wait > 2'd1 ? S_STALL : S_IDLE;
      end else if (state == S_STALL) begin
        cnt   <= (id_valid && cnt > 2'd1) ? cnt - 2'd1 : 2'd0;
        state <= (id_valid && cnt > 2'd1) ? S_STALL : S_IDLE;
      end
      cnt_branch <= sat(cnt_branch, resolve);
      cnt_taken  <= sat(cnt_taken, resolve && cond);
      cnt_stall  <= sat(cnt_stall, stall_id);
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: table-driven and sequence checks for branch_resolve_ctrl
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;
  typedef struct {
    logic v; logic [5:0] op; logic [4:0] rs, rt; logic [31:0] ra, rb;
    logic exw, exl; logic [4:0] exr; logic mw, ml; logic [4:0] mr; logic [31:0] mres;
    logic s, bv, bt, lw;
  } vec_t;
  logic clk = 0, rst = 1;
  logic id_valid, ex_we, ex_is_load, mem_we, mem_is_load, ext_stall;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic [31:0] rs_rdata, rt_rdata, mem_result;
  logic stall_id, branch_valid, branch_taken, link_we;
  logic [4:0] link_reg;
  logic [31:0] cnt_branch, cnt_taken, cnt_stall;
  logic s4, v4, t4, l4;
  logic [4:0] r4;
  logic [3:0] cb4, ct4, cs4;
  int total = 0, bad = 0, dur;
  int eb = 0, et = 0, es = 0;
  vec_t vecs[22];
  vec_t v;
  always #5 clk = ~clk;
  branch_resolve_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
    .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_wreg(mem_wreg), .mem_result(mem_result),
    .ext_stall(ext_stall), .stall_id(stall_id), .branch_valid(branch_valid), .branch_taken(branch_taken),
    .link_we(link_we), .link_reg(link_reg), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
  );
  branch_resolve_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
    .rs_rdata(rs_rdata), .rt_rdata(rt_rdata), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wreg(ex_wreg),
    .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_wreg(mem_wreg), .mem_result(mem_result),
    .ext_stall(ext_stall), .stall_id(s4), .branch_valid(v4), .branch_taken(t4),
    .link_we(l4), .link_reg(r4), .cnt_branch(cb4), .cnt_taken(ct4), .cnt_stall(cs4)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t x);
    id_valid = x.v; id_op = x.op; id_rs = x.rs; id_rt = x.rt; rs_rdata = x.ra; rt_rdata = x.rb;
    ex_we = x.exw; ex_is_load = x.exl; ex_wreg = x.exr;
    mem_we = x.mw; mem_is_load = x.ml; mem_wreg = x.mr; mem_result = x.mres;
  endtask
  task automatic idle();
    id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; rs_rdata = 0; rt_rdata = 0;
    ex_we = 0; ex_is_load = 0; ex_wreg = 0; mem_we = 0; mem_is_load = 0; mem_wreg = 0; mem_result = 0;
    ext_stall = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    vecs[0]  = '{1, OP_BEQ, 5, 5, 32'h10, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[1]  = '{1, OP_BEQ, 5, 6, 32'h10, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, OP_BNE, 5, 6, 32'h10, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[3]  = '{1, OP_BGTZ, 9, 0, 32'h5, 0, 0, 0, 0, 1, 0, 9, 32'h0, 0, 1, 0, 0};
    vecs[4]  = '{1, OP_BGTZ, 9, 0, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[5]  = '{1, OP_BLEZ, 3, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[6]  = '{1, OP_BLEZ, 3, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[7]  = '{1, OP_BLEZ, 3, 0, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{1, OP_REGIMM, 4, 5'b10000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    vecs[9]  = '{1, OP_REGIMM, 4, 5'b10001, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[10] = '{1, OP_REGIMM, 4, 5'b00000, 32'h7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[11] = '{1, OP_REGIMM, 4, 5'b00001, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[12] = '{1, OP_REGIMM, 4, 5'b00010, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{1, 6'b000000, 4, 4, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{1, OP_BEQ, 0, 0, 32'h0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[15] = '{1, OP_BEQ, 4, 7, 32'h0, 0, 1, 0, 7, 0, 0, 0, 0, 1, 0, 0, 0};
    vecs[16] = '{1, OP_BLEZ, 4, 0, 32'h0, 0, 0, 0, 0, 1, 1, 4, 0, 1, 0, 0, 0};
    vecs[17] = '{1, OP_BGTZ, 4, 7, 32'h1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 1, 1, 0};
    vecs[18] = '{0, OP_BEQ, 5, 5, 32'h1, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[19] = '{1, OP_BEQ, 2, 3, 32'h55, 32'h0, 0, 0, 0, 1, 0, 3, 32'h55, 0, 1, 1, 0};
    vecs[20] = '{1, OP_BEQ, 2, 3, 32'h0, 0, 1, 0, 2, 1, 0, 2, 0, 1, 0, 0, 0};
    vecs[21] = '{1, OP_BEQ, 5, 5, 32'h1, 32'h2, 0, 0, 5, 0, 0, 5, 0, 0, 1, 0, 0};
    idle();
    #2;
    chk("reset_stall", stall_id, 0);
    chk("reset_valid", branch_valid, 0);
    chk("reset_cnt", cnt_branch | cnt_taken | cnt_stall, 0);
    step();
    rst = 0;
    foreach (vecs[i]) begin
      step();
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), stall_id, vecs[i].s);
      chk($sformatf("v%0d_valid", i), branch_valid, vecs[i].bv);
      chk($sformatf("v%0d_taken", i), branch_taken, vecs[i].bv & vecs[i].bt);
      chk($sformatf("v%0d_link", i), link_we, vecs[i].lw);
      eb += int'(vecs[i].bv);
      et += int'(vecs[i].bv & vecs[i].bt);
      es += int'(vecs[i].s);
    end
    chk("link_reg", link_reg, 31);
    step();
    idle();
    chk("tbl_cnt_branch", cnt_branch, eb);
    chk("tbl_cnt_taken", cnt_taken, et);
    chk("tbl_cnt_stall", cnt_stall, es);
    do_reset();
    v = '{1, OP_BNE, 8, 6, 32'h3, 32'h4, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(v);
    @(negedge clk);
    chk("lw_c0_stall", stall_id, 1);
    chk("lw_c0_valid", branch_valid, 0);
    step();
    ex_we = 0; mem_we = 1; mem_is_load = 1; mem_wreg = 8;
    @(negedge clk);
    chk("lw_c1_stall", stall_id, 1);
    chk("lw_c1_valid", branch_valid, 0);
    step();
    mem_we = 0;
    @(negedge clk);
    chk("lw_c2_stall", stall_id, 0);
    chk("lw_c2_valid", branch_valid, 1);
    chk("lw_c2_taken", branch_taken, 1);
    step();
    idle();
    chk("lw_cnt_stall", cnt_stall, 2);
    chk("lw_cnt_branch", cnt_branch, 1);
    chk("lw_cnt_taken", cnt_taken, 1);
    do_reset();
    apply(v);
    dur = 0;
    @(negedge clk);
    dur += int'(stall_id);
    step();
    ext_stall = 1; ex_we = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      @(negedge clk);
      dur += int'(stall_id);
      chk($sformatf("ext_hold%0d_stall", k), stall_id, 1);
      chk($sformatf("ext_hold%0d_valid", k), branch_valid, 0);
    end
    step();
    ext_stall = 0;
    @(negedge clk);
    dur += int'(stall_id);
    step();
    @(negedge clk);
    dur += int'(stall_id);
    chk("ext_resolve_valid", branch_valid, 1);
    chk("ext_stall_duration", dur, 5);
    step();
    ext_stall = 1;
    @(negedge clk);
    chk("ext_idle_valid", branch_valid, 0);
    chk("ext_idle_link", link_we, 0);
    chk("ext_cnt_stall", cnt_stall, 2);
    step();
    chk("ext_cnt_branch_hold", cnt_branch, 1);
    idle();
    do_reset();
    apply(v);
    @(negedge clk);
    chk("abort_c0_stall", stall_id, 1);
    step();
    id_valid = 0;
    @(negedge clk);
    chk("abort_c1_stall", stall_id, 1);
    chk("abort_c1_valid", branch_valid, 0);
    step();
    @(negedge clk);
    chk("abort_c2_stall", stall_id, 0);
    chk("abort_cnt_branch", cnt_branch, 0);
    chk("abort_cnt_stall", cnt_stall, 2);
    step();
    v = '{1, OP_BEQ, 5, 5, 32'h10, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(v);
    @(negedge clk);
    chk("abort_after_valid", branch_valid, 1);
    do_reset();
    v = '{1, OP_BNE, 8, 6, 32'h3, 32'h4, 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(v);
    step();
    #2;
    chk("rst_pre_stall", stall_id, 1);
    rst = 1;
    #1;
    chk("rst_mid_stall", stall_id, 0);
    chk("rst_mid_valid", branch_valid, 0);
    chk("rst_mid_cnt_stall", cnt_stall, 0);
    chk("rst_mid_cnt_branch", cnt_branch, 0);
    do_reset();
    v = '{1, OP_BEQ, 5, 5, 32'h10, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    apply(v);
    repeat (14) step();
    chk("sat_cnt4_14", cb4, 4'hE);
    step();
    chk("sat_cnt4_15", cb4, 4'hF);
    repeat (2) step();
    chk("sat_cnt4_hold", cb4, 4'hF);
    chk("sat_taken4_hold", ct4, 4'hF);
    chk("sat_cnt32_17", cnt_branch, 17);
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
